btc_job_scheduler: RTL and testbench

- Sequencer sitting between the host/register interface and NUM_CORES instances of the miner core.
- Accepts header jobs through a valid/ready handshake and buffers one pending job behind the active job.
- Launches all cores on a shared start toggle, giving each core a disjoint nonce slice, and waits for every core to finish.
- Reports per-core found nonces, or a single "exhausted" result, through a valid/ready result port.

---
 rtl/btc_job_scheduler_pkg.sv | 13 +
 rtl/btc_job_scheduler_if.sv | 23 ++
 rtl/btc_found_scanner.sv | 37 +++
 rtl/btc_job_scheduler.sv | 155 +++++++++++++++
 tb/tb_btc_job_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/btc_job_scheduler_pkg.sv
// btc_job_scheduler_pkg: shared constants, FSM encoding and nonce slicing for the job scheduler
package btc_job_scheduler_pkg;
  localparam int HDR_WORDS = 8;
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] PAD_LEN = 32'h0000_0280;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;
  function automatic logic [31:0] nonce_slice(input int idx, input int n);
    return (n <= 1) ? 32'd0 : 32'(idx) << (32 - $clog2(n));
  endfunction
endpackage

// File: rtl/btc_job_scheduler_if.sv
// btc_job_scheduler_if: job intake and result handshakes between host and scheduler
interface btc_job_scheduler_if #(parameter int JOB_ID_W = 8);
  import btc_job_scheduler_pkg::*;
  logic job_valid;
  logic job_ready;
  logic [32*HDR_WORDS-1:0] job_pre_hash;
  logic [31:0] job_merkle_root_7;
  logic [31:0] job_btime;
  logic [31:0] job_bits;
  logic result_valid;
  logic result_ready;
  logic result_found;
  logic [31:0] result_nonce;
  logic [JOB_ID_W-1:0] result_job_id;
  modport master (
    output job_valid, job_pre_hash, job_merkle_root_7, job_btime, job_bits, result_ready,
    input job_ready, result_valid, result_found, result_nonce, result_job_id
  );
  modport slave (
    input job_valid, job_pre_hash, job_merkle_root_7, job_btime, job_bits, result_ready,
    output job_ready, result_valid, result_found, result_nonce, result_job_id
  );
endinterface

// File: rtl/btc_found_scanner.sv
// btc_found_scanner: registered found mask with lowest-index-first selection of the next nonce
module btc_found_scanner #(
  parameter int NUM_CORES = 4
) (
  input logic clk,
  input logic rst_n,
  input logic load,
  input logic pop,
  input logic [NUM_CORES-1:0] found,
  input logic [32*NUM_CORES-1:0] nonce,
  output logic any,
  output logic [31:0] sel_nonce
);
  localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic [NUM_CORES-1:0] mask;
  logic [32*NUM_CORES-1:0] nonce_r;
  logic [IW-1:0] idx;
  // latch the found vector and retire the selected core on each pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      nonce_r <= '0;
    end else if (load) begin
      mask <= found;
      nonce_r <= nonce;
    end else if (pop) begin
      mask <= mask & ~(NUM_CORES'(1) << idx);
    end
  end
  // lowest remaining found index wins
  always_comb begin
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) idx = mask[i] ? IW'(i) : idx;
  end
  assign any = |mask;
  assign sel_nonce = nonce_r[32*int'(idx) +: 32];
endmodule

// File: rtl/btc_job_scheduler.sv
// btc_job_scheduler: buffers header jobs, launches miner cores on a shared toggle and reports finds
module btc_job_scheduler
  import btc_job_scheduler_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int LAUNCH_TIMEOUT = 16,
  parameter int JOB_ID_W = 8
) (
  input logic clk,
  input logic arst_n_a,
  btc_job_scheduler_if.slave bus,
  output logic core_start_a,
  output logic core_use_nonce_in_a,
  output logic core_oneshot_a,
  output logic [32*HDR_WORDS-1:0] core_pre_hash_a,
  output logic [31:0] core_merkle_root_7_a,
  output logic [31:0] core_btime_a,
  output logic [31:0] core_bits_a,
  output logic [32*NUM_CORES-1:0] core_nonce_in_a,
  input logic [NUM_CORES-1:0] core_done,
  input logic [NUM_CORES-1:0] core_found,
  input logic [32*NUM_CORES-1:0] core_nonce,
  output logic busy,
  output logic launch_err
);
  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);
  logic [1:0] rst_sync;
  logic rst_n;
  logic [1:0] state;
  logic [TW-1:0] timer;
  logic pend_v;
  logic [32*HDR_WORDS-1:0] pend_hash;
  logic [31:0] pend_mr, pend_bt, pend_bits;
  logic [JOB_ID_W-1:0] pend_id, id_cnt, act_id;
  logic [32*NUM_CORES-1:0] slice;
  logic rv, rf, emit_none;
  logic [31:0] rn;
  logic [JOB_ID_W-1:0] rid;
  logic job_acc, launch, present, accept, sc_load, sc_pop, sc_any;
  logic [31:0] sc_nonce;
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
    assign slice[32*i +: 32] = nonce_slice(i, NUM_CORES);
  end
  assign rst_n = rst_sync[1];
  assign bus.job_ready = rst_n && !pend_v;
  assign job_acc = bus.job_valid && bus.job_ready;
  assign launch = state == ST_IDLE && pend_v;
  assign present = state == ST_REPORT && !rv && (sc_any || emit_none);
  assign accept = rv && bus.result_ready;
  assign sc_load = state == ST_RUN && &core_done;
  assign sc_pop = present && sc_any;
  assign busy = state != ST_IDLE;
  assign core_use_nonce_in_a = 1'b1;
  assign core_oneshot_a = 1'b0;
  assign bus.result_valid = rv;
  assign bus.result_found = rf;
  assign bus.result_nonce = rn;
  assign bus.result_job_id = rid;
  // assert immediately, release after two clean edges
  always_ff @(posedge clk or negedge arst_n_a) begin
    if (!arst_n_a) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  // single-entry pending buffer with id tagging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v <= 1'b0;
      pend_hash <= '0;
      pend_mr <= '0;
      pend_bt <= '0;
      pend_bits <= '0;
      pend_id <= '0;
      id_cnt <= '0;
    end else if (job_acc) begin
      pend_v <= 1'b1;
      pend_hash <= bus.job_pre_hash;
      pend_mr <= bus.job_merkle_root_7;
      pend_bt <= bus.job_btime;
      pend_bits <= bus.job_bits;
      pend_id <= id_cnt;
      id_cnt <= id_cnt + 1'b1;
    end else if (launch) begin
      pend_v <= 1'b0;
    end
  end
  // core configuration only moves when a job launches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_pre_hash_a <= '0;
      core_merkle_root_7_a <= '0;
      core_btime_a <= '0;
      core_bits_a <= '0;
      core_nonce_in_a <= '0;
      act_id <= '0;
    end else if (launch) begin
      core_pre_hash_a <= pend_hash;
      core_merkle_root_7_a <= pend_mr;
      core_btime_a <= pend_bt;
      core_bits_a <= pend_bits;
      core_nonce_in_a <= slice;
      act_id <= pend_id;
    end
  end
  // launch/run/report sequencing and registered result port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
      core_start_a <= 1'b0;
      launch_err <= 1'b0;
      emit_none <= 1'b0;
      rv <= 1'b0;
      rf <= 1'b0;
      rn <= '0;
      rid <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pend_v) begin
          core_start_a <= ~core_start_a;
          timer <= '0;
          state <= ST_LAUNCH;
        end
        ST_LAUNCH: if (~|core_done) state <= ST_RUN;
          else if (timer == TW'(LAUNCH_TIMEOUT - 1)) begin
            launch_err <= 1'b1;
            state <= ST_IDLE;
          end else timer <= timer + 1'b1;
        ST_RUN: if (&core_done) begin
          emit_none <= ~|core_found;
          state <= ST_REPORT;
        end
        default: if (accept) begin
          rv <= 1'b0;
          state <= (!sc_any && !emit_none) ? ST_IDLE : ST_REPORT;
        end else if (present) begin
          rv <= 1'b1;
          rf <= sc_any;
          rn <= sc_any ? sc_nonce : 32'd0;
          rid <= act_id;
          emit_none <= 1'b0;
        end else if (!rv) state <= ST_IDLE;
      endcase
    end
  end
  btc_found_scanner #(.NUM_CORES(NUM_CORES)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .load(sc_load),
    .pop(sc_pop),
    .found(core_found),
    .nonce(core_nonce),
    .any(sc_any),
    .sel_nonce(sc_nonce)
  );
endmodule

// File: tb/tb_btc_job_scheduler.sv
// tb_btc_job_scheduler: directed checks of intake, launch, reporting, timeout and reset
module tb_btc_job_scheduler;
  logic clk = 1'b0;
  logic arst_n_a = 1'b0;
  logic core_start_a, core_use_nonce_in_a, core_oneshot_a, busy, launch_err;
  logic [255:0] core_pre_hash_a;
  logic [31:0] core_merkle_root_7_a, core_btime_a, core_bits_a;
  logic [127:0] core_nonce_in_a;
  logic [3:0] core_done = 4'hF;
  logic [3:0] core_found = 4'h0;
  logic [127:0] core_nonce = '0;
  int total = 0;
  int bad = 0;
  logic prev;
  btc_job_scheduler_if #(.JOB_ID_W(8)) bus ();
  always #5 clk = ~clk;
  btc_job_scheduler #(.NUM_CORES(4), .LAUNCH_TIMEOUT(16), .JOB_ID_W(8)) dut (
    .clk(clk),
    .arst_n_a(arst_n_a),
    .bus(bus),
    .core_start_a(core_start_a),
    .core_use_nonce_in_a(core_use_nonce_in_a),
    .core_oneshot_a(core_oneshot_a),
    .core_pre_hash_a(core_pre_hash_a),
    .core_merkle_root_7_a(core_merkle_root_7_a),
    .core_btime_a(core_btime_a),
    .core_bits_a(core_bits_a),
    .core_nonce_in_a(core_nonce_in_a),
    .core_done(core_done),
    .core_found(core_found),
    .core_nonce(core_nonce),
    .busy(busy),
    .launch_err(launch_err)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic send_job(input logic [31:0] tag);
    int w = 0;
    bus.job_valid = 1'b1;
    bus.job_pre_hash = {8{tag}};
    bus.job_merkle_root_7 = tag ^ 32'h0000_FFFF;
    bus.job_btime = tag + 32'd7;
    bus.job_bits = ~tag;
    while (!bus.job_ready && w < 50) begin
      tick;
      w++;
    end
    chk("job_ready_wait", 128'(w < 50), 128'd1);
    tick;
    bus.job_valid = 1'b0;
  endtask
  task automatic wait_toggle(input logic p);
    int w = 0;
    while (core_start_a === p && w < 50) begin
      tick;
      w++;
    end
    chk("toggle", 128'(core_start_a), 128'(!p));
  endtask
  task automatic core_run(input logic [3:0] f, input logic [127:0] n);
    core_done = 4'h0;
    tick;
    tick;
    core_found = f;
    core_nonce = n;
    core_done = 4'hF;
  endtask
  task automatic get_result(input logic f, input logic [31:0] n, input logic [7:0] id, input int stall);
    int w = 0;
    while (!bus.result_valid && w < 100) begin
      tick;
      w++;
    end
    chk("result_wait", 128'(w < 100), 128'd1);
    chk("result_found", 128'(bus.result_found), 128'(f));
    chk("result_nonce", 128'(bus.result_nonce), 128'(n));
    chk("result_job_id", 128'(bus.result_job_id), 128'(id));
    for (int i = 0; i < stall; i++) begin
      tick;
      chk("stall_valid", 128'(bus.result_valid), 128'd1);
      chk("stall_nonce", 128'(bus.result_nonce), 128'(n));
    end
    bus.result_ready = 1'b1;
    tick;
    bus.result_ready = 1'b0;
    chk("valid_drop", 128'(bus.result_valid), 128'd0);
  endtask
  initial begin
    bus.job_valid = 1'b0;
    bus.job_pre_hash = '0;
    bus.job_merkle_root_7 = '0;
    bus.job_btime = '0;
    bus.job_bits = '0;
    bus.result_ready = 1'b0;
    repeat (3) tick;
    chk("rst_job_ready", 128'(bus.job_ready), 128'd0);
    chk("rst_start", 128'(core_start_a), 128'd0);
    chk("rst_result_valid", 128'(bus.result_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_launch_err", 128'(launch_err), 128'd0);
    chk("rst_nonce_in", core_nonce_in_a, 128'd0);
    chk("rst_bits", 128'(core_bits_a), 128'd0);
    chk("use_nonce_in", 128'(core_use_nonce_in_a), 128'd1);
    chk("oneshot", 128'(core_oneshot_a), 128'd0);
    arst_n_a = 1'b1;
    tick;
    chk("sync_rel_1", 128'(bus.job_ready), 128'd0);
    tick;
    chk("sync_rel_2", 128'(bus.job_ready), 128'd1);
    // single find on core 2
    prev = core_start_a;
    send_job(32'h1111_2222);
    wait_toggle(prev);
    chk("nonce_slices", core_nonce_in_a, {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
    chk("cfg_bits", 128'(core_bits_a), 128'(32'hEEEE_DDDD));
    chk("cfg_btime", 128'(core_btime_a), 128'(32'h1111_2229));
    chk("cfg_mr", 128'(core_merkle_root_7_a), 128'(32'h1111_DDDD));
    chk("cfg_hash_w7", 128'(core_pre_hash_a[255:224]), 128'(32'h1111_2222));
    chk("busy_launch", 128'(busy), 128'd1);
    core_run(4'b0100, {32'hDEAD_0003, 32'h8000_1234, 32'hDEAD_0001, 32'hDEAD_0000});
    get_result(1'b1, 32'h8000_1234, 8'd0, 0);
    chk("busy_done1", 128'(busy), 128'd0);
    // cores 0 and 3 find, first result stalled
    prev = core_start_a;
    send_job(32'h3333_4444);
    wait_toggle(prev);
    core_run(4'b1001, {32'hC000_0020, 32'hAAAA_0002, 32'hAAAA_0001, 32'h0000_0010});
    get_result(1'b1, 32'h0000_0010, 8'd1, 5);
    get_result(1'b1, 32'hC000_0020, 8'd1, 0);
    chk("busy_done2", 128'(busy), 128'd0);
    // nothing found
    prev = core_start_a;
    send_job(32'h5555_6666);
    wait_toggle(prev);
    core_run(4'b0000, {32'h1, 32'h2, 32'h3, 32'h4});
    get_result(1'b0, 32'h0, 8'd2, 0);
    chk("busy_done3", 128'(busy), 128'd0);
    // second job offered during RUN
    prev = core_start_a;
    send_job(32'h7777_8888);
    wait_toggle(prev);
    prev = core_start_a;
    core_done = 4'h0;
    tick;
    tick;
    chk("ready_in_run", 128'(bus.job_ready), 128'd1);
    bus.job_valid = 1'b1;
    bus.job_bits = 32'h0BAD_0B17;
    tick;
    bus.job_valid = 1'b0;
    chk("ready_after_acc", 128'(bus.job_ready), 128'd0);
    tick;
    chk("ready_held", 128'(bus.job_ready), 128'd0);
    chk("cfg_held", 128'(core_bits_a), 128'(32'h8888_7777));
    core_found = 4'b0010;
    core_nonce = {32'h0, 32'h0, 32'h4000_0055, 32'h0};
    core_done = 4'hF;
    get_result(1'b1, 32'h4000_0055, 8'd3, 0);
    wait_toggle(prev);
    chk("ready_after_launch", 128'(bus.job_ready), 128'd1);
    chk("cfg_job4", 128'(core_bits_a), 128'(32'h0BAD_0B17));
    core_run(4'b0000, '0);
    get_result(1'b0, 32'h0, 8'd4, 0);
    // cores never drop done: launch timeout
    prev = core_start_a;
    send_job(32'h9999_AAAA);
    wait_toggle(prev);
    repeat (15) tick;
    chk("err_not_yet", 128'(launch_err), 128'd0);
    tick;
    chk("err_set", 128'(launch_err), 128'd1);
    chk("err_idle", 128'(busy), 128'd0);
    repeat (3) tick;
    chk("err_no_result", 128'(bus.result_valid), 128'd0);
    chk("err_sticky", 128'(launch_err), 128'd1);
    // reset while a result is offered
    prev = core_start_a;
    send_job(32'hBBBB_CCCC);
    wait_toggle(prev);
    core_run(4'b0001, {96'h0, 32'h0000_0077});
    begin
      int w = 0;
      while (!bus.result_valid && w < 100) begin
        tick;
        w++;
      end
      chk("rst_test_result", 128'(bus.result_valid), 128'd1);
    end
    arst_n_a = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.result_valid), 128'd0);
    chk("mid_rst_ready", 128'(bus.job_ready), 128'd0);
    chk("mid_rst_err", 128'(launch_err), 128'd0);
    chk("mid_rst_start", 128'(core_start_a), 128'd0);
    tick;
    arst_n_a = 1'b1;
    tick;
    chk("rel_ready_1", 128'(bus.job_ready), 128'd0);
    tick;
    chk("rel_ready_2", 128'(bus.job_ready), 128'd1);
    send_job(32'hDDDD_EEEE);
    wait_toggle(1'b0);
    core_run(4'b1000, {32'hC000_0099, 96'h0});
    get_result(1'b1, 32'hC000_0099, 8'd0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
